// File: rtl/left_shifter_16bit_pkg.sv
// Processor-wide datapath constants and types shared by the shifter slice.
package left_shifter_16bit_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned SHAMT_W = 4;

    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [SHAMT_W-1:0] shamt_t;

endpackage : left_shifter_16bit_pkg

// File: rtl/left_shifter_16bit_if.sv
// Operand/result bus of the registered left shifter.
interface left_shifter_16bit_if;
    import left_shifter_16bit_pkg::*;

    logic   in_valid;
    data_t  A;
    shamt_t mag;
    data_t  Q;
    logic   carry;
    logic   zero;
    logic   out_valid;

    modport master (
        output in_valid, A, mag,
        input  Q, carry, zero, out_valid
    );

    modport slave (
        input  in_valid, A, mag,
        output Q, carry, zero, out_valid
    );

endinterface : left_shifter_16bit_if

// File: rtl/left_shifter_16bit_shl_stage.sv
// One zero-filling barrel stage: shifts left by DIST when en is set and
// forwards the last bit to leave the word along the carry chain.
module shl_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIST  = 1
) (
    input  logic [WIDTH-1:0] d_in,
    input  logic             en,
    input  logic             c_in,
    output logic [WIDTH-1:0] d_out,
    output logic             c_out
);

    always_comb begin
        d_out = d_in;
        c_out = c_in;
        if (en) begin
            d_out = d_in << DIST;
            // The lowest of the bits pushed past the MSB is the one that leaves last.
            c_out = d_in[WIDTH-DIST];
        end
    end

endmodule : shl_stage

// File: rtl/left_shifter_16bit.sv
// Registered 16-bit logical left barrel shifter with carry-out and zero flag.
module left_shifter_16bit
    import left_shifter_16bit_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned LOG2  = SHAMT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    left_shifter_16bit_if.slave  bus
);

    logic [WIDTH-1:0] stage_d [LOG2+1];
    logic             stage_c [LOG2+1];

    logic [WIDTH-1:0] q_d, q_q;
    logic             carry_d, carry_q;
    logic             zero_d, zero_q;
    logic             out_valid_d, out_valid_q;

    always_comb begin
        stage_d[0] = bus.A;
        stage_c[0] = 1'b0;
    end

    // Stage i shifts by 2**i under mag[i]; the carry chain keeps the bit
    // dropped by the last enabled stage, which is A[WIDTH-mag].
    for (genvar i = 0; i < LOG2; i++) begin : g_stage
        shl_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << i)
        ) u_stage (
            .d_in  (stage_d[i]),
            .en    (bus.mag[i]),
            .c_in  (stage_c[i]),
            .d_out (stage_d[i+1]),
            .c_out (stage_c[i+1])
        );
    end

    always_comb begin
        q_d         = q_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        out_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            q_d     = stage_d[LOG2];
            carry_d = stage_c[LOG2];
            zero_d  = (stage_d[LOG2] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q         <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            q_q         <= q_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.Q         = q_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = out_valid_q;

endmodule : left_shifter_16bit

// File: tb/tb_left_shifter_16bit.sv
// Self-checking bench for left_shifter_16bit: directed cases plus random
// traffic against an arithmetic reference model.
module tb_left_shifter_16bit;

    logic clk;
    logic rst_n;

    left_shifter_16bit_if bus ();

    left_shifter_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [15:0] exp_q;
    logic        exp_c;
    logic        exp_z;
    logic        exp_v;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        exp_q = 16'h0000;
        exp_c = 1'b0;
        exp_z = 1'b1;
        exp_v = 1'b0;
    endtask

    // Shift in a 32-bit space: bit 16 is then exactly the last bit to leave.
    task automatic model_load(input logic [15:0] a, input logic [3:0] m);
        logic [31:0] full;
        full  = {16'h0000, a} << m;
        exp_q = full[15:0];
        exp_c = (m == 4'd0) ? 1'b0 : full[16];
        exp_z = (full[15:0] == 16'h0000);
        exp_v = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".Q"},         {16'h0, bus.Q},         {16'h0, exp_q});
        check_eq({tag, ".carry"},     {31'h0, bus.carry},     {31'h0, exp_c});
        check_eq({tag, ".zero"},      {31'h0, bus.zero},      {31'h0, exp_z});
        check_eq({tag, ".out_valid"}, {31'h0, bus.out_valid}, {31'h0, exp_v});
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs sampled likewise.
    task automatic step(input string tag, input logic [15:0] a, input logic [3:0] m, input logic v);
        bus.A        = a;
        bus.mag      = m;
        bus.in_valid = v;
        @(posedge clk);
        if (v) model_load(a, m);
        else   exp_v = 1'b0;
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.A        = 16'h0;
        bus.mag      = 4'h0;
        model_reset();

        @(posedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b1;
        step("idle0", 16'hFFFF, 4'h3, 1'b0);
        step("idle1", 16'h1234, 4'h7, 1'b0);

        for (int unsigned i = 0; i < 16; i++)
            step("walk1", 16'h0001, 4'(i), 1'b1);

        step("edge_1111_f", 16'h1111, 4'hF, 1'b1);
        check_eq("edge_1111_f.Qconst", {16'h0, bus.Q}, 32'h0000_8000);
        step("edge_0101_5", 16'h0101, 4'h5, 1'b1);
        check_eq("edge_0101_5.Qconst", {16'h0, bus.Q}, 32'h0000_2020);
        step("cz_ffff_4", 16'hFFFF, 4'h4, 1'b1);
        check_eq("cz_ffff_4.Qconst", {16'h0, bus.Q}, 32'h0000_FFF0);
        step("cz_8000_1", 16'h8000, 4'h1, 1'b1);
        check_eq("cz_8000_1.carryconst", {31'h0, bus.carry}, 32'h1);
        step("mag15_carry", 16'h0002, 4'hF, 1'b1);
        step("zero_a", 16'h0000, 4'h9, 1'b1);
        step("pass_a5c3", 16'hA5C3, 4'h0, 1'b1);
        step("hold_a5c3", 16'h5A3C, 4'h2, 1'b0);
        check_eq("hold_a5c3.Qconst", {16'h0, bus.Q}, 32'h0000_A5C3);

        // Reset mid-stream: drop rst_n between edges with a result pending.
        step("pre_rst", 16'h00F0, 4'h4, 1'b1);
        bus.A        = 16'h0F0F;
        bus.mag      = 4'h3;
        bus.in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("midrst");
        @(posedge clk);
        #1;
        check_outputs("midrst_hold");
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        step("post_rst", 16'hBEEF, 4'h1, 1'b0);

        for (int unsigned i = 0; i < 10000; i++)
            step("rand", 16'($urandom), 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_left_shifter_16bit

// File: doc/left_shifter_16bit.md
Name: left_shifter_16bit

Overview:
- Registered 16-bit logical left barrel shifter for the 16-bit processor datapath (ALU shift path).
- Shifts operand A left by 0..15 positions, zero-filling from the LSB.
- Result, carry-out and zero flag are presented one clock after a valid input.

Parameters:
- WIDTH, 16, data width; fixed at 16 for this block, with the shift amount LOG2 bits wide.
- LOG2, 4, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A and mag are valid this cycle.
- A  input  16  operand to shift.
- mag  input  4  shift amount, unsigned 0..15.
- Q  output  16  shifted result, registered.
- carry  output  1  last bit shifted out of bit 15, registered.
- zero  output  1  1 when Q == 16'h0000, registered.
- out_valid  output  1  Q, carry and zero are valid this cycle.

Behaviour:
- Reset (rst_n low, asynchronous): Q=16'h0000, carry=0, zero=1, out_valid=0. Outputs hold these values until the first valid input after release.
- Combinational core: Q_next = (A << mag) truncated to 16 bits. Bits shifted past bit 15 are discarded; vacated LSBs are 0.
- Core structure: four cascaded mux stages, shifting by 1, 2, 4 and 8 when mag[0], mag[1], mag[2] and mag[3] are set respectively. Each stage zero-fills.
- carry_next:
  - mag==0: 0.
  - otherwise: A[16-mag], the last bit to leave the word.
- zero_next = (Q_next == 0).
- Latency: 1 cycle.
  - On a rising clk edge with in_valid=1: Q, carry and zero load their next values, and out_valid goes to 1.
  - On a rising clk edge with in_valid=0: out_valid goes to 0, and Q, carry and zero hold their previous values.
- Throughput: one operation per cycle; back-to-back valid inputs give back-to-back results. There is no backpressure.
- Boundaries:
  - mag=0: Q=A, carry=0.
  - mag=15: Q={A[0],15'b0}, carry=A[1].
  - A=0: Q=0, zero=1, carry=0 for any mag.
- Reset mid-stream: outputs clear immediately to their reset values, and any in-flight result is lost.
- Arithmetic rules:
  - No sign handling; this is a logical shift only.
  - mag is treated as unsigned; all 4-bit values are legal, so there are no out-of-range cases.

Decomposition:
- Shared package (processor-wide), containing:
  - DATA_W=16
  - SHAMT_W=4
  - a data-word typedef and a shift-amount typedef
- Sub-module shl_stage:
  - parameterised shift distance; inputs are data and an enable bit; output is data shifted by the distance when enabled, else passed through unchanged.
  - also exports the bits shifted out, used to compute carry.
  - left_shifter_16bit instantiates shl_stage four times (distances 1, 2, 4, 8) and adds the output register stage and flag logic.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> Q=0000, carry=0, zero=1, out_valid=0 immediately. Release, then apply no valid input -> outputs stay at reset values.
- Walking one: A=16'h0001, mag=0..15 sequentially with in_valid=1 -> one cycle later Q=16'h0001<<mag (0001, 0002, 0004 ... 8000). carry=0 and zero=0 throughout; out_valid=1 each cycle.
- Edge shifts:
  - A=16'h1111, mag=F -> Q=16'h8000, carry=0.
  - A=16'h0101, mag=5 -> Q=16'h2020, carry=0.
- Carry and zero:
  - A=16'hFFFF, mag=4 -> Q=16'hFFF0, carry=1, zero=0.
  - A=16'h8000, mag=1 -> Q=16'h0000, carry=1, zero=1.
- Passthrough and hold:
  - A=16'hA5C3, mag=0 -> Q=16'hA5C3, carry=0.
  - Next cycle in_valid=0 with A changed -> Q stays 16'hA5C3, out_valid=0.
- Random: 10,000 random A/mag pairs with random in_valid -> Q, carry and zero match the reference model (A<<mag, A[16-mag], Q==0) with 1-cycle latency.
